// File: rtl/axi_stream_pkg.sv
// rtl/axi_stream_pkg.sv - shared beat-record layout helpers and byte popcount
package axi_stream_pkg;

  localparam int default_byte_width = 4;
  localparam int max_bytes          = 64;

  // FIFO entry layout, LSB first: tdata, tkeep, tstrb, tlast.
  function automatic int beat_rec_width(input int byte_width);
    return 8 * byte_width + 2 * byte_width + 1;
  endfunction

  function automatic int beat_keep_lsb(input int byte_width);
    return 8 * byte_width;
  endfunction

  function automatic int beat_strb_lsb(input int byte_width);
    return 9 * byte_width;
  endfunction

  function automatic int beat_last_bit(input int byte_width);
    return 10 * byte_width;
  endfunction

  function automatic int unsigned popcount(input logic [max_bytes-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < max_bytes; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_stream_slave_fifo_if.sv
// rtl/axi_stream_slave_fifo_if.sv - AXI4-Stream master-to-slave beat channel
interface axi_stream_slave_fifo_if #(
  parameter int byte_width = 4
);
  logic                    tvalid;
  logic                    tready;
  logic [8*byte_width-1:0] tdata;
  logic [byte_width-1:0]   tstrb;
  logic [byte_width-1:0]   tkeep;
  logic                    tlast;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, output tready);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with extra-MSB pointers and occupancy output
module sync_fifo #(
  parameter int width      = 8,
  parameter int depth_log2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [width-1:0]    push_data,
  input  logic                pop,
  output logic [width-1:0]    pop_data,
  output logic                full,
  output logic                empty,
  output logic [depth_log2:0] fill
);
  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] ptr_one = (depth_log2 + 1)'(1);

  logic [width-1:0]    mem [depth];
  logic [depth_log2:0] wr_ptr;
  logic [depth_log2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[depth_log2] != rd_ptr[depth_log2]) &&
                    (wr_ptr[depth_log2-1:0] == rd_ptr[depth_log2-1:0]);
  assign fill     = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[depth_log2-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[depth_log2-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_one;
      if (do_pop)  rd_ptr <= rd_ptr + ptr_one;
    end
  end

endmodule

// File: rtl/axi_stream_slave_fifo.sv
// rtl/axi_stream_slave_fifo.sv - AXI4-Stream sink: FIFO buffering, traffic counters, protocol checks
module axi_stream_slave_fifo
  import axi_stream_pkg::*;
#(
  parameter int byte_width  = default_byte_width,
  parameter int depth_log2  = 4,
  parameter int count_width = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  axi_stream_slave_fifo_if.slave    s,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [8*byte_width-1:0]   rd_data,
  output logic [byte_width-1:0]     rd_keep,
  output logic [byte_width-1:0]     rd_strb,
  output logic                      rd_last,
  output logic [depth_log2:0]       fill,
  output logic [count_width-1:0]    beat_count,
  output logic [count_width-1:0]    byte_count,
  output logic [15:0]               packet_count,
  output logic                      err_strb,
  output logic                      err_stable
);
  localparam int rec_w    = beat_rec_width(byte_width);
  localparam int keep_lsb = beat_keep_lsb(byte_width);
  localparam int strb_lsb = beat_strb_lsb(byte_width);
  localparam int last_bit = beat_last_bit(byte_width);
  localparam logic [depth_log2:0] almost_full = (depth_log2 + 1)'((1 << depth_log2) - 1);

  logic             tready_q;
  logic             tready_d;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [rec_w-1:0] push_rec;
  logic [rec_w-1:0] head_rec;
  logic             armed_q;
  logic             prev_valid;
  logic             prev_ready;
  logic [rec_w-1:0] prev_rec;
  logic             strb_bad;
  logic             stable_bad;

  assign s.tready = tready_q;
  assign accept   = s.tvalid && tready_q;
  // Empty non-last beats carry nothing worth keeping; empty last beats still mark the boundary.
  assign push     = accept && ((s.tkeep != '0) || s.tlast);
  assign pop      = rd_valid && rd_ready;
  assign push_rec = {s.tlast, s.tstrb, s.tkeep, s.tdata};

  assign rd_valid = !empty;
  assign rd_data  = head_rec[8*byte_width-1:0];
  assign rd_keep  = head_rec[keep_lsb +: byte_width];
  assign rd_strb  = head_rec[strb_lsb +: byte_width];
  assign rd_last  = head_rec[last_bit];

  // Ready for next cycle looks at post-edge occupancy so a full FIFO never sees an extra push.
  assign tready_d = pop || !(full || (push && (fill == almost_full)));

  assign strb_bad   = s.tvalid && ((s.tstrb & ~s.tkeep) != '0);
  assign stable_bad = armed_q && prev_valid && !prev_ready &&
                      (!s.tvalid || (push_rec != prev_rec));

  sync_fifo #(
    .width      (rec_w),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (full),
    .empty     (empty),
    .fill      (fill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tready_q     <= 1'b0;
      armed_q      <= 1'b0;
      prev_valid   <= 1'b0;
      prev_ready   <= 1'b0;
      prev_rec     <= '0;
      beat_count   <= '0;
      byte_count   <= '0;
      packet_count <= '0;
      err_strb     <= 1'b0;
      err_stable   <= 1'b0;
    end else begin
      tready_q   <= tready_d;
      armed_q    <= 1'b1;
      prev_valid <= s.tvalid;
      prev_ready <= tready_q;
      prev_rec   <= push_rec;
      if (accept) begin
        beat_count   <= beat_count + count_width'(1);
        byte_count   <= byte_count + count_width'(popcount(max_bytes'(s.tkeep)));
        packet_count <= packet_count + 16'(s.tlast);
      end
      if (strb_bad)   err_strb   <= 1'b1;
      if (stable_bad) err_stable <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_stream_slave_fifo.sv
// tb/tb_axi_stream_slave_fifo.sv - randomized and directed bench for axi_stream_slave_fifo
module tb_axi_stream_slave_fifo;
  localparam int BW    = 4;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_stream_slave_fifo_if #(.byte_width(BW)) bus ();

  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic [3:0]  rd_keep, rd_strb;
  logic [4:0]  fill;
  logic [31:0] beat_count, byte_count;
  logic [15:0] packet_count;
  logic        err_strb, err_stable;

  axi_stream_slave_fifo #(.byte_width(BW), .depth_log2(DL), .count_width(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .s            (bus),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_keep      (rd_keep),
    .rd_strb      (rd_strb),
    .rd_last      (rd_last),
    .fill         (fill),
    .beat_count   (beat_count),
    .byte_count   (byte_count),
    .packet_count (packet_count),
    .err_strb     (err_strb),
    .err_stable   (err_stable)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  s;
    logic        l;
  } rec_t;

  rec_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_beats, m_bytes;
  logic [15:0] m_pkts;
  logic        m_tready, m_err_strb, m_err_stable, m_armed;
  logic        p_valid, p_ready, p_l, last_acc;
  logic [31:0] p_d;
  logic [3:0]  p_k, p_s;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_beats = 0; m_bytes = 0; m_pkts = 0;
    m_tready = 0; m_err_strb = 0; m_err_stable = 0; m_armed = 0;
    p_valid = 0; p_ready = 0; p_d = 0; p_k = 0; p_s = 0; p_l = 0; last_acc = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic [3:0] s, input logic l, input logic rr);
    bus.tvalid = v; bus.tdata = d; bus.tkeep = k; bus.tstrb = s; bus.tlast = l;
    rd_ready = rr;
  endtask

  // One clock: compare DUT against model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic acc, pp;
    @(negedge clk);
    chk("tready", 64'(bus.tready), 64'(m_tready));
    chk("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    chk("fill", 64'(fill), 64'(q.size()));
    chk("beat_count", 64'(beat_count), 64'(m_beats));
    chk("byte_count", 64'(byte_count), 64'(m_bytes));
    chk("packet_count", 64'(packet_count), 64'(m_pkts));
    chk("err_strb", 64'(err_strb), 64'(m_err_strb));
    chk("err_stable", 64'(err_stable), 64'(m_err_stable));
    if (q.size() != 0) begin
      chk("rd_data", 64'(rd_data), 64'(q[0].d));
      chk("rd_keep", 64'(rd_keep), 64'(q[0].k));
      chk("rd_strb", 64'(rd_strb), 64'(q[0].s));
      chk("rd_last", 64'(rd_last), 64'(q[0].l));
    end
    acc = bus.tvalid && m_tready;
    pp  = (q.size() != 0) && rd_ready;
    @(posedge clk);
    if (bus.tvalid && ((bus.tstrb & ~bus.tkeep) != 4'h0)) m_err_strb = 1;
    if (m_armed && p_valid && !p_ready &&
        (!bus.tvalid || bus.tdata != p_d || bus.tkeep != p_k || bus.tstrb != p_s || bus.tlast != p_l))
      m_err_stable = 1;
    if (pp) void'(q.pop_front());
    if (acc) begin
      m_beats += 32'd1;
      m_bytes += 32'($countones(bus.tkeep));
      m_pkts  += 16'(bus.tlast);
      if (bus.tkeep != 4'h0 || bus.tlast)
        q.push_back('{d: bus.tdata, k: bus.tkeep, s: bus.tstrb, l: bus.tlast});
    end
    p_valid = bus.tvalid; p_ready = m_tready;
    p_d = bus.tdata; p_k = bus.tkeep; p_s = bus.tstrb; p_l = bus.tlast;
    m_armed  = 1;
    last_acc = acc;
    m_tready = (q.size() < DEPTH);
    #1;
  endtask

  // Asserts reset between edges and expects outputs to clear with no clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_tready", 64'(bus.tready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_beats", 64'(beat_count), 64'd0);
    chk("rst_bytes", 64'(byte_count), 64'd0);
    chk("rst_pkts", 64'(packet_count), 64'd0);
    chk("rst_err_strb", 64'(err_strb), 64'd0);
    chk("rst_err_stable", 64'(err_stable), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic        v, l;
  logic [31:0] d;
  logic [3:0]  k, s;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_clear();

    // Fill and drain
    do_reset();
    cycle();
    chk("ff_tready_up", 64'(bus.tready), 64'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h1000 + i, 4'hF, 4'hF, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("ff_tready_full", 64'(bus.tready), 64'd0);
    chk("ff_fill", 64'(fill), 64'd16);
    chk("ff_beats", 64'(beat_count), 64'd16);
    chk("ff_bytes", 64'(byte_count), 64'd64);
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("ff_order", 64'(rd_data), 64'(32'h1000 + i));
      cycle();
      if (i == 0) chk("ff_tready_back", 64'(bus.tready), 64'd1);
    end
    chk("ff_empty", 64'(rd_valid), 64'd0);

    // Null beats
    do_reset();
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hDEAD0000 + i, 4'h0, 4'h0, 0, 0);
      cycle();
    end
    drive(1, 32'hBEEF, 4'h0, 4'h0, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    chk("null_beats", 64'(beat_count), 64'd4);
    chk("null_bytes", 64'(byte_count), 64'd0);
    chk("null_fill", 64'(fill), 64'd1);
    chk("null_pkts", 64'(packet_count), 64'd1);
    chk("null_last", 64'(rd_last), 64'd1);
    cycle();

    // Partial keep
    do_reset();
    cycle();
    drive(1, 32'h11111111, 4'hF, 4'hF, 0, 0); cycle();
    drive(1, 32'h22222222, 4'hF, 4'hF, 0, 0); cycle();
    drive(1, 32'h00003333, 4'h3, 4'h3, 1, 0); cycle();
    drive(0, 0, 0, 0, 0, 1);
    chk("pk_bytes", 64'(byte_count), 64'd10);
    chk("pk_pkts", 64'(packet_count), 64'd1);
    cycle();
    cycle();
    chk("pk_final_keep", 64'(rd_keep), 64'h3);
    chk("pk_final_last", 64'(rd_last), 64'd1);
    cycle();
    chk("pk_drained", 64'(fill), 64'd0);

    // Strobe violation
    do_reset();
    cycle();
    drive(1, 32'hCAFE0001, 4'h1, 4'h3, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    chk("strb_err", 64'(err_strb), 64'd1);
    chk("strb_stored", 64'(rd_strb), 64'h3);
    chk("strb_keep", 64'(rd_keep), 64'h1);
    repeat (3) cycle();
    chk("strb_sticky", 64'(err_strb), 64'd1);

    // Stability violation
    do_reset();
    cycle();
    drive(1, 32'hA5A5A5A5, 4'hF, 4'hF, 0, 0);
    repeat (16) cycle();
    cycle();
    chk("stab_pre", 64'(err_stable), 64'd0);
    drive(1, 32'h5A5A5A5A, 4'hF, 4'hF, 0, 0);
    cycle();
    chk("stab_err", 64'(err_stable), 64'd1);
    drive(1, 32'h5A5A5A5A, 4'hF, 4'hF, 0, 1);
    repeat (3) cycle();
    drive(0, 0, 0, 0, 0, 1);
    repeat (20) cycle();
    chk("stab_sticky", 64'(err_stable), 64'd1);

    // Stability control: hold the stalled beat unchanged until it is taken
    do_reset();
    cycle();
    drive(1, 32'hA5A5A5A5, 4'hF, 4'hF, 0, 0);
    repeat (19) cycle();
    rd_ready = 1;
    cycle();
    cycle();
    drive(0, 0, 0, 0, 0, 1);
    repeat (20) cycle();
    chk("stab_ctrl", 64'(err_stable), 64'd0);

    // Async reset mid-operation with fill=5
    do_reset();
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h7000 + i, 4'hF, 4'hF, (i == 2), 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("mid_fill", 64'(fill), 64'd5);
    do_reset();
    cycle();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1200; n++) begin
      if (!(bus.tvalid && !last_acc)) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
        k = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        s = ($urandom_range(0, 15) == 0) ? 4'($urandom) : (k & 4'($urandom));
        l = ($urandom_range(0, 3) == 0);
        bus.tvalid = v; bus.tdata = d; bus.tkeep = k; bus.tstrb = s; bus.tlast = l;
      end
      if ((n % 300) < 80) rd_ready = 0;
      else rd_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
